// File: rtl/gpu_op_arbiter_pkg.sv
// Shared GPU op definitions used by the arbiter and anything that talks to
// the GPU op port.
package gpu_op_arbiter_pkg;

  // One GPU operation as presented on the op port.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  tag;
    logic [15:0] arg;
  } gpu_op_t;

  localparam int GPU_OP_W = $bits(gpu_op_t);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit,
// searching upward from last+1 and wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    index,
  output logic             any
);

  int idx;

  // Scan candidates from farthest to nearest so the nearest winner is the
  // final assignment.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        index       = IW'(idx);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_op_arbiter.sv
// Shares a single GPU op port among N_REQ requesters. One op is in flight at
// a time: accept -> one-cycle issue pulse -> fixed hold-off while the GPU's
// ready flag is not yet meaningful -> wait for ready -> idle again.
//
// Handshakes: a requester op transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational, one-hot, and only
// ever high in IDLE with ce=1, rst_n=1 and gpu_op_ready=1. gpu_op_valid is a
// registered pulse; gpu_op_ready is a level meaning "GPU idle".
module gpu_op_arbiter
  import gpu_op_arbiter_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic [N_REQ*GPU_OP_W-1:0] req_op,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  output gpu_op_t                   gpu_op,
  output logic                      gpu_op_valid,
  input  logic                      gpu_op_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    HOLDOFF    = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [IW-1:0]     last_grant;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_index;
  logic              pick_any;
  logic              accept;
  logic              release_grant;
  gpu_op_t           sel_op;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req_valid),
    .last   (last_grant),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // Mux the winning requester's op onto the capture path.
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_onehot[i]) sel_op = gpu_op_t'(req_op[i*GPU_OP_W +: GPU_OP_W]);
    end
  end

  // Next-state, hold-off count and the combinational acceptance strobe.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    req_ready     = '0;
    accept        = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && ce && gpu_op_ready && pick_any) begin
          req_ready  = pick_onehot;
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = HOLDOFF;
        cnt_next   = CW'(HOLDOFF_CYCLES);
      end
      HOLDOFF: begin
        if (cnt <= CW'(1)) begin
          state_next = WAIT_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      WAIT_READY: begin
        if (gpu_op_ready) begin
          state_next    = IDLE;
          release_grant = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over ce, ce=0 freezes everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // Datapath registers: captured op, owner, round-robin pointer, counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpu_op       <= '0;
      gpu_op_valid <= 1'b0;
      grant        <= '0;
      cnt          <= '0;
      last_grant   <= IW'(N_REQ - 1);
    end else if (ce) begin
      cnt          <= cnt_next;
      gpu_op_valid <= (state_next == ISSUE);
      if (accept) begin
        gpu_op     <= sel_op;
        grant      <= pick_onehot;
        last_grant <= pick_index;
      end else if (release_grant) begin
        grant <= '0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Bench for gpu_op_arbiter: directed scenarios followed by random traffic,
// checked by a transaction-level reference model and an issue scoreboard.
module tb_gpu_op_arbiter;
  import gpu_op_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int H  = 1;
  localparam int W  = GPU_OP_W;
  localparam int EW = N + W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              ce;
  logic [N*W-1:0]    req_op;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  gpu_op_t           gpu_op;
  logic              gpu_op_valid;
  logic              gpu_op_ready;
  logic [N-1:0]      grant;
  logic              busy;
  logic [1:0]        state_dbg;

  gpu_op_arbiter #(.N_REQ(N), .HOLDOFF_CYCLES(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .req_op       (req_op),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .gpu_op       (gpu_op),
    .gpu_op_valid (gpu_op_valid),
    .gpu_op_ready (gpu_op_ready),
    .grant        (grant),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pulse = 0;
  logic [EW-1:0] exp_q[$];
  logic [N-1:0]  obs_g[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: either idle, or some number of enabled edges since the
  // last acceptance. Age 0 is the issue cycle, ages 1..H are hold-off, and
  // beyond H the arbiter waits for gpu_op_ready.
  bit            m_ok   = 1'b0;
  bit            m_idle = 1'b1;
  int            m_age  = 0;
  int            m_last = N - 1;
  logic [W-1:0]  m_op   = '0;

  function automatic int ref_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : model
    logic [N-1:0] e_rdy;
    int p;
    e_rdy = '0;
    p = -1;
    if (!rst_n) begin
      chk("ready_in_reset", req_ready, 0);
      m_ok = 1'b1; m_idle = 1'b1; m_age = 0; m_last = N - 1; m_op = '0;
      exp_q.delete();
    end else if (m_ok) begin
      chk("busy", busy, !m_idle);
      chk("op_valid", gpu_op_valid, (!m_idle && m_age == 0));
      chk("grant", grant, m_idle ? 0 : (1 << m_last));
      chk("op_hold", gpu_op, m_op);
      if (m_idle && ce && gpu_op_ready) p = ref_pick(req_valid, m_last);
      if (p >= 0) e_rdy[p] = 1'b1;
      chk("req_ready", req_ready, e_rdy);
      if (ce) begin
        if (p >= 0) begin
          m_idle = 1'b0; m_age = 0; m_last = p;
          m_op = req_op[p*W +: W];
          exp_q.push_back({e_rdy, m_op});
          n_acc++;
        end else if (!m_idle) begin
          if (m_age > H && gpu_op_ready) m_idle = 1'b1;
          else m_age++;
        end
      end
    end
  end

  // ---------------- issue monitor ----------------
  logic prev_v = 1'b0;
  int   cur_len = 0;
  int   last_len = 0;

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (gpu_op_valid === 1'b1 && !prev_v) begin
      n_pulse++;
      obs_g.push_back(grant);
      chk("issue_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_grant_op", {grant, gpu_op}, e);
      end
      cur_len = 1;
    end else if (gpu_op_valid === 1'b1) begin
      cur_len++;
    end else if (prev_v) begin
      last_len = cur_len;
    end
    prev_v = (gpu_op_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic c, logic r, logic [N-1:0] v);
    ce = c;
    gpu_op_ready = r;
    req_valid = v;
    for (int i = 0; i < N; i++) req_op[i*W +: W] = W'($urandom());
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_n = 1'b0;
    ce = 1'b0;
    req_valid = '0;
    gpu_op_ready = 1'b0;
    req_op = '0;
    step(3);
    rst_n = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 0);
    chk("reset_op", gpu_op, 0);
    chk("reset_valid", gpu_op_valid, 0);

    // first acceptance goes to requester 0, pulse one cycle later
    drive(1, 1, 2'b01);
    #3 chk("first_ready", req_ready, 2'b01);
    step(1);
    chk("first_pulse_high", gpu_op_valid, 1);
    drive(1, 1, 2'b00);
    step(1);
    chk("first_pulse_low", gpu_op_valid, 0);
    step(5);

    // both requesting, GPU ready three cycles after each issue
    drive(1, 1, 2'b00);
    do_reset(2);
    obs_g.delete();
    k = 3;
    for (int c = 0; c < 40; c++) begin
      drive(1, (k >= 3), 2'b11);
      step(1);
      if (gpu_op_valid) k = 0;
      else k++;
    end
    drive(1, 1, 2'b00);
    step(6);
    chk("alt_count", obs_g.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk("alt_grant_seq", (obs_g.size() > i) ? obs_g[i] : '0, (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int i = 1; i < obs_g.size(); i++)
      chk("alt_no_repeat", obs_g[i] != obs_g[i-1], 1);

    // GPU stays busy for 20 cycles after an issue
    drive(1, 1, 2'b11);
    step(1);
    drive(1, 0, 2'b11);
    step(20);
    drive(1, 1, 2'b11);
    #3 chk("wait_no_ready", req_ready, 0);
    step(1);
    #3 chk("wait_accept_after", |req_ready, 1);
    step(1);
    drive(1, 1, 2'b00);
    step(8);

    // clock enable low for five cycles during the issue pulse
    drive(1, 1, 2'b01);
    step(1);
    drive(0, 1, 2'b00);
    step(5);
    drive(1, 1, 2'b00);
    step(6);
    chk("stretch_len", last_len, 6);

    // reset during hold-off abandons the op
    drive(1, 1, 2'b11);
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant, 0);
    chk("abort_op", gpu_op, 0);
    rst_n = 1'b1;
    obs_g.delete();
    step(1);
    drive(1, 1, 2'b00);
    step(6);
    chk("abort_first_grant", (obs_g.size() > 0) ? obs_g[0] : '0, 2'b01);

    // requester 1 flickers while busy
    drive(1, 1, 2'b01);
    step(1);
    drive(1, 1, 2'b10);
    step(1);
    drive(1, 1, 2'b00);
    step(8);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), N'($urandom()));
      step(1);
    end
    drive(1, 1, 2'b00);
    step(10);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("pulses_eq_accepts", n_pulse, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
